binary_decoder38_seq: RTL and testbench

Sequenced 3-to-8 binary decoder. It is the companion of the team's 8-to-3 encoder and drives the one-hot select lines that encoder consumes. It accepts 3-bit codes over a valid/ready handshake, holds each decoded one-hot value on q for a programmable number of cycles, then inserts an optional all-zero gap. A one-entry pending buffer lets codes stream without bubbles.

---
 rtl/binary_decoder38_seq.sv | 147 ++++++++++++++
 tb/tb_binary_decoder38_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/binary_decoder38_seq.sv
// Sequenced 3-to-8 decoder: accepts codes over valid/ready, holds each one-hot
// value for HOLD cycles, inserts GAP zero cycles, with a one-entry pending slot.
module binary_decoder38_seq #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] d,
    output logic [7:0] q,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    q_q, q_d;
    logic          done_q, done_d;
    logic          pend_full_q, pend_full_d;
    logic [2:0]    pend_q, pend_d;

    logic          accept;
    logic          has_next;
    logic [2:0]    next_code;

    function automatic logic [7:0] onehot(input logic [2:0] c);
        return 8'(1) << c;
    endfunction

    // in_ready is gated by rst_n so it reads low while reset is held
    assign in_ready  = rst_n && En && !pend_full_q;
    assign accept    = in_valid && in_ready;
    assign has_next  = pend_full_q || accept;
    assign next_code = pend_full_q ? pend_q : d;

    assign q    = q_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE) || pend_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        done_d      = 1'b0;
        pend_full_d = pend_full_q;
        pend_d      = pend_q;

        if (!En) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            q_d         = '0;
            pend_full_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_DRIVE;
                        q_d     = onehot(d);
                        cnt_d   = HOLD_LD;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (accept) begin
                            pend_full_d = 1'b1;
                            pend_d      = d;
                        end
                    end else begin
                        done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            q_d     = '0;
                            cnt_d   = GAP_LD;
                            if (accept) begin
                                pend_full_d = 1'b1;
                                pend_d      = d;
                            end
                        end else if (has_next) begin
                            // pending and a fresh accept are exclusive, so consuming clears the slot
                            q_d         = onehot(next_code);
                            cnt_d       = HOLD_LD;
                            pend_full_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            q_d     = '0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (accept) begin
                            pend_full_d = 1'b1;
                            pend_d      = d;
                        end
                    end else if (has_next) begin
                        state_d     = S_DRIVE;
                        q_d         = onehot(next_code);
                        cnt_d       = HOLD_LD;
                        pend_full_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            done_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            done_q      <= done_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_binary_decoder38_seq.sv
// Self-checking bench: per-cycle vector table through a scoreboard queue,
// two configurations (HOLD=4/GAP=1 and HOLD=1/GAP=0), plus reset sequences.
module tb_binary_decoder38_seq;

    logic       clk = 1'b0;
    bit         clk_run = 1'b0;
    logic       rst_n;
    logic       en0, vld0, en1, vld1;
    logic [2:0] d0, d1;
    logic       rdy0, rdy1, busy0, busy1, done0, done1;
    logic [7:0] q0, q1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         dut;
        bit         en;
        bit         vld;
        logic [2:0] d;
        logic [7:0] q;
        bit         done;
        bit         busy;
        bit         rdy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    binary_decoder38_seq #(.HOLD(4), .GAP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .En(en0), .in_valid(vld0), .in_ready(rdy0),
        .d(d0), .q(q0), .busy(busy0), .done(done0)
    );

    binary_decoder38_seq #(.HOLD(1), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .En(en1), .in_valid(vld1), .in_ready(rdy1),
        .d(d1), .q(q1), .busy(busy1), .done(done1)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add(input bit dut, input bit en, input bit vld, input logic [2:0] d,
                                input logic [7:0] q, input bit done, input bit busy, input bit rdy);
        vec_t v;
        v.dut = dut; v.en = en; v.vld = vld; v.d = d;
        v.q = q; v.done = done; v.busy = busy; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t       e;
        logic [7:0] one;
        logic [7:0] aq;
        logic       ad, ab, ar;

        // single code d=5 on HOLD=4/GAP=1
        add(0,1,1,5, 8'h00,0,0,1);
        for (int i = 0; i < 4; i++) add(0,1,0,0, 8'h20,0,1,1);
        add(0,1,0,0, 8'h00,1,1,1);
        add(0,1,0,0, 8'h00,0,0,1);
        // back-to-back 0 then 7
        add(0,1,1,0, 8'h00,0,0,1);
        add(0,1,1,7, 8'h01,0,1,1);
        for (int i = 0; i < 3; i++) add(0,1,0,0, 8'h01,0,1,0);
        add(0,1,0,0, 8'h00,1,1,0);
        for (int i = 0; i < 4; i++) add(0,1,0,0, 8'h80,0,1,1);
        add(0,1,0,0, 8'h00,1,1,1);
        add(0,1,0,0, 8'h00,0,0,1);
        // streaming 1,2,3 on HOLD=1/GAP=0
        add(1,1,1,1, 8'h00,0,0,1);
        add(1,1,1,2, 8'h02,0,1,1);
        add(1,1,1,3, 8'h04,1,1,1);
        add(1,1,0,0, 8'h08,1,1,1);
        add(1,1,0,0, 8'h00,1,0,1);
        add(1,1,0,0, 8'h00,0,0,1);
        // all eight codes streamed
        one = 8'h01;
        for (int k = 0; k < 8; k++)
            add(1,1,1,3'(k), (k == 0) ? 8'h00 : (one << (k - 1)), k >= 2, k >= 1, 1);
        add(1,1,0,0, 8'h80,1,1,1);
        add(1,1,0,0, 8'h00,1,0,1);
        add(1,1,0,0, 8'h00,0,0,1);
        // abort: d=6 driving, code 2 pending, En dropped after two drive cycles
        add(0,1,1,6, 8'h00,0,0,1);
        add(0,1,1,2, 8'h40,0,1,1);
        add(0,1,0,0, 8'h40,0,1,0);
        add(0,0,0,0, 8'h40,0,1,0);
        add(0,0,0,0, 8'h00,0,0,0);
        for (int i = 0; i < 6; i++) add(0,1,0,0, 8'h00,0,0,1);

        // reset with clock stopped
        rst_n = 1'b0;
        en0 = 1'b1; vld0 = 1'b0; d0 = '0;
        en1 = 1'b1; vld1 = 1'b0; d1 = '0;
        #20;
        chk("rst_q0", q0, 8'h00);
        chk("rst_done0", {7'b0, done0}, 8'h00);
        chk("rst_busy0", {7'b0, busy0}, 8'h00);
        chk("rst_rdy0", {7'b0, rdy0}, 8'h00);
        chk("rst_q1", q1, 8'h00);
        chk("rst_rdy1", {7'b0, rdy1}, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy0", {7'b0, rdy0}, 8'h01);
        chk("rel_rdy1", {7'b0, rdy1}, 8'h01);
        chk("rel_q0", q0, 8'h00);
        clk_run = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].dut == 1'b0) begin
                en0 = vecs[i].en; vld0 = vecs[i].vld; d0 = vecs[i].d;
                en1 = 1'b1; vld1 = 1'b0;
            end else begin
                en1 = vecs[i].en; vld1 = vecs[i].vld; d1 = vecs[i].d;
                en0 = 1'b1; vld0 = 1'b0;
            end
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e  = exp_q.pop_front();
            aq = e.dut ? q1    : q0;
            ad = e.dut ? done1 : done0;
            ab = e.dut ? busy1 : busy0;
            ar = e.dut ? rdy1  : rdy0;
            chk($sformatf("row%0d_q", i),    aq,          e.q);
            chk($sformatf("row%0d_done", i), {7'b0, ad},  {7'b0, e.done});
            chk($sformatf("row%0d_busy", i), {7'b0, ab},  {7'b0, e.busy});
            chk($sformatf("row%0d_rdy", i),  {7'b0, ar},  {7'b0, e.rdy});
        end

        // asynchronous reset mid-DRIVE with a code pending
        @(posedge clk); #1; en0 = 1'b1; vld0 = 1'b1; d0 = 3'd6; vld1 = 1'b0;
        @(posedge clk); #1; d0 = 3'd3;
        @(posedge clk); #1; vld0 = 1'b0;
        chk("arst_pre_q", q0, 8'h40);
        chk("arst_pre_busy", {7'b0, busy0}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", q0, 8'h00);
        chk("arst_busy", {7'b0, busy0}, 8'h00);
        chk("arst_rdy", {7'b0, rdy0}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("arst_post%0d_q", i), q0, 8'h00);
            chk($sformatf("arst_post%0d_busy", i), {7'b0, busy0}, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
